// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU memory stage and a word-wide data memory.
// Sub-word stores use read-modify-write so neighbouring bytes survive.
module dmem_lsu #(
    parameter int ADDR_DEPTH = 14,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [1:0]            REQ_SIZE,
    input  logic                  REQ_SIGN,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [ADDR_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [ADDR_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  MEM_RDEN,
    output logic                  MEM_WEN,
    output logic [1:0]            MEM_BYTE_SEL,
    output logic                  MEM_SIGN,
    output logic [ADDR_DEPTH-1:0] MEM_ADDR,
    output logic [ADDR_WIDTH-1:0] MEM_DATA_OUT,
    input  logic [ADDR_WIDTH-1:0] MEM_DATA_IN
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_CAPTURE,
        RMW_ISSUE,
        RMW_CAPTURE,
        WR_ISSUE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  mem_rden_q, mem_rden_d;
    logic                  mem_wen_q, mem_wen_d;
    logic [ADDR_DEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0] mem_data_out_q, mem_data_out_d;

    logic                  accept;
    logic                  req_mis;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [ADDR_WIDTH-1:0] ld_data;
    logic [ADDR_WIDTH-1:0] st_merged;
    logic                  unused_addr_hi;

    // Upper address bits belong to the memory's own base decode.
    assign unused_addr_hi = ^REQ_ADDR[ADDR_WIDTH-1:ADDR_DEPTH+2];

    assign REQ_READY = (state_q == IDLE) & ~RST;
    assign accept    = REQ_VALID & REQ_READY;
    assign req_mis   = ((REQ_SIZE == 2'b01) & REQ_ADDR[0])
                     | (REQ_SIZE[1] & (|REQ_ADDR[1:0]));

    always_comb begin
        ld_byte = MEM_DATA_IN[{lane_q, 3'b000} +: 8];
        ld_half = MEM_DATA_IN[{lane_q[1], 4'b0000} +: 16];
        unique case (size_q)
            2'b00:   ld_data = {{(ADDR_WIDTH-8){sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{(ADDR_WIDTH-16){sign_q & ld_half[15]}}, ld_half};
            default: ld_data = MEM_DATA_IN;
        endcase
    end

    always_comb begin
        st_merged = MEM_DATA_IN;
        if (size_q == 2'b00) begin
            st_merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            st_merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        size_d         = size_q;
        sign_d         = sign_q;
        lane_d         = lane_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_err_d      = 1'b0;
        mem_rden_d     = 1'b0;
        mem_wen_d      = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d     = REQ_SIZE;
                    sign_d     = REQ_SIGN;
                    lane_d     = REQ_ADDR[1:0];
                    wdata_d    = REQ_WDATA[15:0];
                    mem_addr_d = REQ_ADDR[ADDR_DEPTH+1:2];
                    if (req_mis) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!REQ_WE) begin
                        state_d    = LD_ISSUE;
                        mem_rden_d = 1'b1;
                    end else if (REQ_SIZE[1]) begin
                        state_d        = WR_ISSUE;
                        mem_wen_d      = 1'b1;
                        mem_data_out_d = REQ_WDATA;
                    end else begin
                        state_d    = RMW_ISSUE;
                        mem_rden_d = 1'b1;
                    end
                end
            end
            LD_ISSUE:   state_d = LD_CAPTURE;
            LD_CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld_data;
            end
            RMW_ISSUE:  state_d = RMW_CAPTURE;
            RMW_CAPTURE: begin
                state_d        = WR_ISSUE;
                mem_wen_d      = 1'b1;
                mem_data_out_d = st_merged;
            end
            WR_ISSUE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            size_q         <= 2'b00;
            sign_q         <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            mem_rden_q     <= 1'b0;
            mem_wen_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
        end else begin
            state_q        <= state_d;
            size_q         <= size_d;
            sign_q         <= sign_d;
            lane_q         <= lane_d;
            wdata_q        <= wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            mem_rden_q     <= mem_rden_d;
            mem_wen_q      <= mem_wen_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
        end
    end

    assign RSP_VALID    = rsp_valid_q;
    assign RSP_RDATA    = rsp_rdata_q;
    assign RSP_ERR      = rsp_err_q;
    assign MEM_RDEN     = mem_rden_q;
    assign MEM_WEN      = mem_wen_q;
    assign MEM_BYTE_SEL = 2'b10;
    assign MEM_SIGN     = 1'b0;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_DATA_OUT = mem_data_out_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word memory model and a response scoreboard.
module tb_dmem_lsu;

    localparam int AD = 14;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [1:0]    REQ_SIZE;
    logic          REQ_SIGN;
    logic [AW-1:0] REQ_ADDR;
    logic [AW-1:0] REQ_WDATA;
    logic          RSP_VALID;
    logic [AW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic          MEM_RDEN;
    logic          MEM_WEN;
    logic [1:0]    MEM_BYTE_SEL;
    logic          MEM_SIGN;
    logic [AD-1:0] MEM_ADDR;
    logic [AW-1:0] MEM_DATA_OUT;
    logic [AW-1:0] MEM_DATA_IN;

    dmem_lsu #(.ADDR_DEPTH(AD), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_RDEN(MEM_RDEN), .MEM_WEN(MEM_WEN),
        .MEM_BYTE_SEL(MEM_BYTE_SEL), .MEM_SIGN(MEM_SIGN),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA_OUT(MEM_DATA_OUT),
        .MEM_DATA_IN(MEM_DATA_IN)
    );

    always #5 CLK = ~CLK;

    // Registered-read memory, read has priority over write.
    logic [AW-1:0] mem [0:(1<<AD)-1];
    logic [AW-1:0] mem_rd;
    always @(posedge CLK) begin
        if (MEM_RDEN) mem_rd <= mem[MEM_ADDR];
        else if (MEM_WEN) mem[MEM_ADDR] <= MEM_DATA_OUT;
    end
    assign MEM_DATA_IN = mem_rd;

    typedef struct {
        logic [AW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          sbq[$];
    logic [AW-1:0] ref_mem [0:(1<<AD)-1];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            rden_cnt = 0;
    int            wen_cnt = 0;
    bit            overlap = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [1:0] sz,
                                   input logic sg, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t          e;
        logic [31:0]   w, b, h, m;
        int            sh;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.acc   = 0;
        if ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        w  = ref_mem[a[AD+1:2]];
        sh = 8 * int'(a[1:0]);
        if (!we) begin
            e.lat = 3;
            if (sz == 2'b00) begin
                b = (w >> sh) & 32'hFF;
                e.rdata = (sg && b[7]) ? (b | 32'hFFFFFF00) : b;
            end else if (sz == 2'b01) begin
                h = (w >> sh) & 32'hFFFF;
                e.rdata = (sg && h[15]) ? (h | 32'hFFFF0000) : h;
            end else begin
                e.rdata = w;
            end
        end else begin
            if (sz == 2'b00) begin
                m = 32'hFF << sh;
                w = (w & ~m) | ((wd & 32'hFF) << sh);
                e.lat = 4;
            end else if (sz == 2'b01) begin
                m = 32'hFFFF << sh;
                w = (w & ~m) | ((wd & 32'hFFFF) << sh);
                e.lat = 4;
            end else begin
                w = wd;
                e.lat = 2;
            end
            ref_mem[a[AD+1:2]] = w;
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (MEM_RDEN) rden_cnt++;
            if (MEM_WEN) wen_cnt++;
            if (MEM_RDEN && MEM_WEN) overlap = 1'b1;
            if (RSP_VALID) begin
                checks++;
                assert (sbq.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_rsp observed=1 expected=0");
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("rsp_rdata", RSP_RDATA, e.rdata);
                    check("rsp_err", 32'(RSP_ERR), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat - 1));
                end
            end
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input bit push);
        int   n;
        exp_t e;
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_SIZE  = sz;
        REQ_SIGN  = sg;
        REQ_ADDR  = a;
        REQ_WDATA = wd;
        n = 0;
        while (!REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("accept_ready", 32'(REQ_READY), 32'h1);
        if (REQ_READY) begin
            if (push) begin
                e = model(we, sz, sg, a, wd);
                e.acc = cyc + 1;
                sbq.push_back(e);
            end
            @(posedge CLK);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("drain_empty", 32'(sbq.size()), 32'h0);
    endtask

    int r0, w0;

    initial begin
        fork
            monitor();
        join_none
        RST = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE = 1'b0;
        REQ_SIZE = 2'b00;
        REQ_SIGN = 1'b0;
        REQ_ADDR = '0;
        REQ_WDATA = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", 32'(REQ_READY), 32'h0);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'h0);
        check("rst_rsp_rdata", RSP_RDATA, 32'h0);
        check("rst_rsp_err", 32'(RSP_ERR), 32'h0);
        check("rst_rden", 32'(MEM_RDEN), 32'h0);
        check("rst_wen", 32'(MEM_WEN), 32'h0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'h0);
        check("rst_mem_dout", MEM_DATA_OUT, 32'h0);
        check("byte_sel", 32'(MEM_BYTE_SEL), 32'h2);
        check("mem_sign", 32'(MEM_SIGN), 32'h0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_idle", 32'(REQ_READY), 32'h1);

        send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
        idle();
        drain();
        send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        idle();
        drain();

        send(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 1'b1);
        send(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AB, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1);
        idle();
        drain();

        send(1'b1, 2'b10, 1'b0, 32'h300, 32'h80FF7F01, 1'b1);
        send(1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 1'b1);
        send(1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 1'b1);
        send(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 1'b1);
        send(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 32'h300, 32'h0, 1'b1);
        idle();
        drain();

        r0 = rden_cnt;
        w0 = wen_cnt;
        send(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h402, 32'h0, 1'b1);
        send(1'b1, 2'b11, 1'b0, 32'h403, 32'h12345678, 1'b1);
        idle();
        drain();
        check("mis_no_rden", 32'(rden_cnt), 32'(r0));
        check("mis_no_wen", 32'(wen_cnt), 32'(w0));

        send(1'b1, 2'b10, 1'b0, 32'h500, 32'h55667788, 1'b1);
        idle();
        drain();
        w0 = wen_cnt;
        send(1'b1, 2'b00, 1'b0, 32'h501, 32'h000000EE, 1'b0);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_rst", 32'(REQ_READY), 32'h1);
        repeat (8) @(negedge CLK);
        check("rst_no_wen", 32'(wen_cnt), 32'(w0));
        send(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b1);
        idle();
        drain();

        send(1'b1, 2'b10, 1'b0, 32'hF0000600, 32'hCAFEF00D, 1'b1);
        send(1'b1, 2'b01, 1'b0, 32'h602, 32'h0000BEEF, 1'b1);
        send(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge CLK);
        check("no_rd_wr_overlap", 32'(overlap), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
